// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short-click, double-click and long-press
// events, presented on a one-entry valid/ready register with a sticky overflow flag.
module button_event_decoder #(
  parameter int LONG_CYCLES       = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 25_000_000,
  parameter int CNT_W             = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    GAP,
    WAIT_RELEASE
  } state_t;

  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_DOUBLE = 2'b10;
  localparam logic [1:0] CODE_LONG   = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_prev_q;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic             overflow_q, overflow_d;
  logic             emit;
  logic [1:0]       emit_code;
  logic             rise;

  // btn_prev resets high so a button held through reset never looks like a rise.
  assign rise = button & ~btn_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_prev_q  <= 1'b1;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 2'b00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_prev_q  <= button;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_code = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = CNT_ONE;
        end
      end
      PRESSED: begin
        if (button) begin
          if (cnt_q == LONG_LAST) begin
            emit      = 1'b1;
            emit_code = CODE_LONG;
            state_d   = WAIT_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // The release sample is already the first low of the gap.
          state_d = GAP;
          cnt_d   = CNT_ONE;
        end
      end
      GAP: begin
        if (button) begin
          emit      = 1'b1;
          emit_code = CODE_DOUBLE;
          state_d   = WAIT_RELEASE;
        end else if (cnt_q == GAP_LAST) begin
          emit      = 1'b1;
          emit_code = CODE_SHORT;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (!button) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full register that is being drained this cycle can take the new event.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    overflow_d  = overflow_q;
    if (emit) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = emit_code;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios plus random button traffic,
// compared every cycle against a run-length reference model.
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int GAPN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: classification by run lengths of highs and lows.
  bit m_prev, m_pressing, m_waiting, m_ignoring;
  int m_hi_run, m_lo_run;
  bit m_v, m_ovf;
  int m_code;

  // Transfer tally for directed scenarios.
  int cyc_no = 0;
  int n_evt, first_idx, first_code, last_code;

  button_event_decoder #(
    .LONG_CYCLES(LONG),
    .DOUBLE_GAP_CYCLES(GAPN),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b1; m_pressing = 0; m_waiting = 0; m_ignoring = 0;
    m_hi_run = 0; m_lo_run = 0; m_v = 0; m_ovf = 0; m_code = 0;
  endtask

  task automatic model_step(input bit b, input bit r);
    int ev;
    ev = 0;
    if (m_ignoring) begin
      if (!b) m_ignoring = 0;
    end else if (m_pressing) begin
      if (b) begin
        m_hi_run++;
        if (m_hi_run == LONG) begin ev = 3; m_pressing = 0; m_ignoring = 1; end
      end else begin
        m_pressing = 0; m_waiting = 1; m_lo_run = 1;
      end
    end else if (m_waiting) begin
      if (b) begin
        ev = 2; m_waiting = 0; m_ignoring = 1;
      end else begin
        m_lo_run++;
        if (m_lo_run == GAPN) begin ev = 1; m_waiting = 0; end
      end
    end else if (b && !m_prev) begin
      m_pressing = 1; m_hi_run = 1;
    end
    m_prev = b;
    if (ev != 0) begin
      if (!m_v || r) begin m_v = 1; m_code = ev; end
      else m_ovf = 1;
    end else if (m_v && r) begin
      m_v = 0;
    end
  endtask

  task automatic cyc(input bit b, input bit r, input bit rs);
    button = b; evt_ready = r; rst = rs;
    @(posedge clk);
    if (rs) model_reset();
    else model_step(b, r);
    @(negedge clk);
    check("evt_valid", 32'(evt_valid), 32'(m_v));
    if (m_v) check("evt_code", 32'(evt_code), 32'(m_code));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (evt_valid && evt_ready) begin
      if (n_evt == 0) begin first_idx = cyc_no; first_code = int'(evt_code); end
      last_code = int'(evt_code);
      n_evt++;
    end
    cyc_no++;
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b1, 1'b0);
  endtask

  task automatic settle_and_clear(output int base);
    run(1'b0, 12);
    n_evt = 0; first_idx = -1; first_code = 0; last_code = 0;
    base = cyc_no;
  endtask

  initial begin
    int base;
    model_reset();
    n_evt = 0;
    @(negedge clk);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code", 32'(evt_code), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Short click
    settle_and_clear(base);
    run(1, 3); run(0, 10);
    check("short_count", n_evt, 1);
    check("short_code", first_code, 1);
    check("short_edge", first_idx - base, 6);

    // Double click
    settle_and_clear(base);
    run(1, 3); run(0, 2); run(1, 5); run(0, 10);
    check("double_count", n_evt, 1);
    check("double_code", first_code, 2);
    check("double_edge", first_idx - base, 5);

    // Long press
    settle_and_clear(base);
    run(1, 20); run(0, 10);
    check("long_count", n_evt, 1);
    check("long_code", first_code, 3);
    check("long_edge", first_idx - base, 7);

    // One sample short of long
    settle_and_clear(base);
    run(1, 7); run(0, 10);
    check("hi7_count", n_evt, 1);
    check("hi7_code", first_code, 1);
    check("hi7_edge", first_idx - base, 10);

    // Gap boundary: rise after GAPN-1 lows is a double
    settle_and_clear(base);
    run(1, 3); run(0, 3); run(1, 2); run(0, 10);
    check("gap3_count", n_evt, 1);
    check("gap3_code", first_code, 2);

    // Gap boundary: after GAPN lows the first press is a short
    settle_and_clear(base);
    run(1, 3); run(0, 4); run(1, 3); run(0, 10);
    check("gap4_first", first_code, 1);
    check("gap4_edge", first_idx - base, 6);

    // Overflow with stalled consumer
    settle_and_clear(base);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0);
    check("ovf_code", 32'(evt_code), 32'd1);
    check("ovf_valid", 32'(evt_valid), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("ovf_drain_valid", 32'(evt_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    cyc(0, 0, 1);
    check("ovf_rst", 32'(overflow), 32'd0);

    // Held through reset
    cyc(1, 1, 1); cyc(1, 1, 1);
    n_evt = 0;
    run(1, 30); run(0, 10);
    check("held_count", n_evt, 0);
    settle_and_clear(base);
    run(1, 3); run(0, 10);
    check("after_held_count", n_evt, 1);
    check("after_held_code", first_code, 1);

    // Reset mid-press
    settle_and_clear(base);
    run(1, 4); cyc(1, 1, 1); run(1, 7); run(0, 10);
    check("rst_press_count", n_evt, 0);
    check("rst_press_valid", 32'(evt_valid), 32'd0);
    check("rst_press_code", 32'(evt_code), 32'd0);
    check("rst_press_ovf", 32'(overflow), 32'd0);

    // Reset mid-gap
    settle_and_clear(base);
    run(1, 3); run(0, 1); cyc(0, 1, 1); run(0, 10);
    check("rst_gap_count", n_evt, 0);

    // Random traffic
    for (int s = 0; s < 300; s++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        cyc(lvl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
